// File: rtl/imm_gen_pkg.sv
// Shared format codes and opcode constants for the pipelined immediate generator.
// No logic.
// No flow control.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Immediate decoder: instruction word -> extended immediate, format, illegal, pc-relative flag.
// Purely combinational, zero cycles.
// No flow control; the parent registers the result.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     op_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o,
    output logic            is_pcrel_o
);

    // RV64 shifts carry a 6-bit shamt, RV32 a 5-bit one.
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh;

    assign opc    = op_i[6:0];
    assign funct3 = op_i[14:12];

    // The sign bit op_i[31] is replicated over everything above the low field bits.
    assign imm_i = {{(XLEN-11){op_i[31]}}, op_i[30:20]};
    assign imm_s = {{(XLEN-11){op_i[31]}}, op_i[30:25], op_i[11:7]};
    assign imm_b = {{(XLEN-12){op_i[31]}}, op_i[7], op_i[30:25], op_i[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){op_i[31]}}, op_i[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){op_i[31]}}, op_i[19:12], op_i[20], op_i[30:21], 1'b0};

    always_comb begin
        imm_sh          = '0;
        imm_sh[SHW-1:0] = op_i[20 +: SHW];
    end

    always_comb begin
        imm_o      = '0;
        fmt_o      = FMT_NONE;
        illegal_o  = 1'b0;
        is_pcrel_o = 1'b0;
        unique case (opc)
            OPC_OPIMM: begin
                if (funct3[1:0] == 2'b01) begin
                    imm_o = imm_sh;
                    fmt_o = FMT_SHAMT;
                end else begin
                    imm_o = imm_i;
                    fmt_o = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                imm_o = imm_i;
                fmt_o = FMT_I;
            end
            OPC_STORE: begin
                imm_o = imm_s;
                fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
                imm_o      = imm_b;
                fmt_o      = FMT_B;
                is_pcrel_o = 1'b1;
            end
            OPC_LUI: begin
                imm_o = imm_u;
                fmt_o = FMT_U;
            end
            OPC_AUIPC: begin
                imm_o      = imm_u;
                fmt_o      = FMT_U;
                is_pcrel_o = 1'b1;
            end
            OPC_JAL: begin
                imm_o      = imm_j;
                fmt_o      = FMT_J;
                is_pcrel_o = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with pc-relative target adder for the decode stage.
// LATENCY register stages (1 or 2) from input acceptance to valid_o; 1/cycle throughput.
// valid/ready: stalls hold outputs bit-stable, upstream fills bubbles; flush kills all entries.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     Op_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] Imm_o,
    output logic [2:0]      fmt_o,
    output logic [XLEN-1:0] Target_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_ill;
    logic            dec_pcrel;
    logic            in_xfer;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .op_i       (Op_i),
        .imm_o      (dec_imm),
        .fmt_o      (dec_fmt),
        .illegal_o  (dec_ill),
        .is_pcrel_o (dec_pcrel)
    );

    assign in_xfer = valid_i && ready_o;

    if (LATENCY == 1) begin : g_lat1
        logic            vld_q, vld_d;
        logic [XLEN-1:0] imm_q, imm_d;
        logic [XLEN-1:0] tgt_q, tgt_d;
        imm_fmt_e        fmt_q, fmt_d;
        logic            ill_q, ill_d;

        assign ready_o = !flush_i && (!vld_q || ready_i);

        always_comb begin
            vld_d = vld_q;
            imm_d = imm_q;
            tgt_d = tgt_q;
            fmt_d = fmt_q;
            ill_d = ill_q;
            if (flush_i) begin
                vld_d = 1'b0;
            end else if (in_xfer) begin
                vld_d = 1'b1;
                imm_d = dec_imm;
                fmt_d = dec_fmt;
                ill_d = dec_ill;
                tgt_d = dec_pcrel ? (pc_i + dec_imm) : '0;
            end else if (vld_q && ready_i) begin
                vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                vld_q <= 1'b0;
                imm_q <= '0;
                tgt_q <= '0;
                fmt_q <= FMT_NONE;
                ill_q <= 1'b0;
            end else begin
                vld_q <= vld_d;
                imm_q <= imm_d;
                tgt_q <= tgt_d;
                fmt_q <= fmt_d;
                ill_q <= ill_d;
            end
        end

        assign valid_o   = vld_q;
        assign Imm_o     = imm_q;
        assign Target_o  = tgt_q;
        assign fmt_o     = fmt_q;
        assign illegal_o = ill_q;
    end else begin : g_lat2
        // Stage 1 holds the decoded fields plus pc; the adder sits between the stages.
        logic            v1_q, v1_d;
        logic [XLEN-1:0] imm1_q, imm1_d;
        logic [XLEN-1:0] pc1_q, pc1_d;
        imm_fmt_e        fmt1_q, fmt1_d;
        logic            ill1_q, ill1_d;
        logic            pcrel1_q, pcrel1_d;

        logic            v2_q, v2_d;
        logic [XLEN-1:0] imm2_q, imm2_d;
        logic [XLEN-1:0] tgt2_q, tgt2_d;
        imm_fmt_e        fmt2_q, fmt2_d;
        logic            ill2_q, ill2_d;

        logic            adv1;

        assign adv1    = v1_q && (!v2_q || ready_i);
        assign ready_o = !flush_i && (!v1_q || adv1);

        always_comb begin
            v1_d     = v1_q;
            imm1_d   = imm1_q;
            pc1_d    = pc1_q;
            fmt1_d   = fmt1_q;
            ill1_d   = ill1_q;
            pcrel1_d = pcrel1_q;
            if (flush_i) begin
                v1_d = 1'b0;
            end else if (in_xfer) begin
                v1_d     = 1'b1;
                imm1_d   = dec_imm;
                pc1_d    = pc_i;
                fmt1_d   = dec_fmt;
                ill1_d   = dec_ill;
                pcrel1_d = dec_pcrel;
            end else if (adv1) begin
                v1_d = 1'b0;
            end
        end

        always_comb begin
            v2_d   = v2_q;
            imm2_d = imm2_q;
            tgt2_d = tgt2_q;
            fmt2_d = fmt2_q;
            ill2_d = ill2_q;
            if (flush_i) begin
                v2_d = 1'b0;
            end else if (adv1) begin
                v2_d   = 1'b1;
                imm2_d = imm1_q;
                fmt2_d = fmt1_q;
                ill2_d = ill1_q;
                tgt2_d = pcrel1_q ? (pc1_q + imm1_q) : '0;
            end else if (v2_q && ready_i) begin
                v2_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                v1_q     <= 1'b0;
                imm1_q   <= '0;
                pc1_q    <= '0;
                fmt1_q   <= FMT_NONE;
                ill1_q   <= 1'b0;
                pcrel1_q <= 1'b0;
                v2_q     <= 1'b0;
                imm2_q   <= '0;
                tgt2_q   <= '0;
                fmt2_q   <= FMT_NONE;
                ill2_q   <= 1'b0;
            end else begin
                v1_q     <= v1_d;
                imm1_q   <= imm1_d;
                pc1_q    <= pc1_d;
                fmt1_q   <= fmt1_d;
                ill1_q   <= ill1_d;
                pcrel1_q <= pcrel1_d;
                v2_q     <= v2_d;
                imm2_q   <= imm2_d;
                tgt2_q   <= tgt2_d;
                fmt2_q   <= fmt2_d;
                ill2_q   <= ill2_d;
            end
        end

        assign valid_o   = v2_q;
        assign Imm_o     = imm2_q;
        assign Target_o  = tgt2_q;
        assign fmt_o     = fmt2_q;
        assign illegal_o = ill2_q;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (32b/L1, 32b/L2, 64b/L2) in lockstep,
// directed vectors plus randomized traffic against an arithmetic reference model.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic [31:0] op;
    logic [63:0] pc;

    logic [31:0] imm0, tgt0, imm1, tgt1;
    logic [63:0] imm2, tgt2;
    logic [2:0]  fmt0, fmt1, fmt2;
    logic        vld0, vld1, vld2, ill0, ill1, ill2, rdy0, rdy1, rdy2;

    logic [63:0] o_imm [3];
    logic [63:0] o_tgt [3];
    logic [2:0]  o_fmt [3];
    logic        o_vld [3];
    logic        o_ill [3];
    logic        o_rdy [3];
    int          xl [3] = '{32, 32, 64};

    exp_t mq [3][4];
    int   mh [3];
    int   mc [3];

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy0),
        .Op_i(op), .pc_i(pc[31:0]), .valid_o(vld0), .ready_i(ready_i),
        .Imm_o(imm0), .fmt_o(fmt0), .Target_o(tgt0), .illegal_o(ill0));

    imm_gen_pipe #(.XLEN(32), .LATENCY(2)) dut_l2 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy1),
        .Op_i(op), .pc_i(pc[31:0]), .valid_o(vld1), .ready_i(ready_i),
        .Imm_o(imm1), .fmt_o(fmt1), .Target_o(tgt1), .illegal_o(ill1));

    imm_gen_pipe #(.XLEN(64), .LATENCY(2)) dut_w64 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy2),
        .Op_i(op), .pc_i(pc), .valid_o(vld2), .ready_i(ready_i),
        .Imm_o(imm2), .fmt_o(fmt2), .Target_o(tgt2), .illegal_o(ill2));

    assign o_imm[0] = {32'h0, imm0};  assign o_imm[1] = {32'h0, imm1};  assign o_imm[2] = imm2;
    assign o_tgt[0] = {32'h0, tgt0};  assign o_tgt[1] = {32'h0, tgt1};  assign o_tgt[2] = tgt2;
    assign o_fmt[0] = fmt0;  assign o_fmt[1] = fmt1;  assign o_fmt[2] = fmt2;
    assign o_vld[0] = vld0;  assign o_vld[1] = vld1;  assign o_vld[2] = vld2;
    assign o_ill[0] = ill0;  assign o_ill[1] = ill1;  assign o_ill[2] = ill2;
    assign o_rdy[0] = rdy0;  assign o_rdy[1] = rdy1;  assign o_rdy[2] = rdy2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Two's-complement interpretation of a bits-wide field.
    function automatic longint sx(input logic [31:0] v, input int bits);
        longint r;
        r = longint'(v);
        if (r >= (longint'(1) << (bits - 1)))
            r = r - (longint'(1) << bits);
        return r;
    endfunction

    function automatic exp_t ref_model(input logic [31:0] o, input logic [63:0] p, input int w);
        exp_t        e;
        longint      imm;
        bit          pcrel;
        logic [63:0] mask;
        imm   = 0;
        pcrel = 0;
        e     = '0;
        case (o[6:0])
            7'h13: begin
                if (o[13:12] == 2'b01) begin
                    e.fmt = 3'd2;
                    imm   = (w == 64) ? longint'(o[25:20]) : longint'(o[24:20]);
                end else begin
                    e.fmt = 3'd1;
                    imm   = sx({20'h0, o[31:20]}, 12);
                end
            end
            7'h03, 7'h67: begin e.fmt = 3'd1; imm = sx({20'h0, o[31:20]}, 12); end
            7'h23: begin e.fmt = 3'd3; imm = sx({20'h0, o[31:25], o[11:7]}, 12); end
            7'h63: begin
                e.fmt = 3'd4; pcrel = 1;
                imm   = sx({19'h0, o[31], o[7], o[30:25], o[11:8], 1'b0}, 13);
            end
            7'h37: begin e.fmt = 3'd5; imm = sx({o[31:12], 12'h0}, 32); end
            7'h17: begin e.fmt = 3'd5; pcrel = 1; imm = sx({o[31:12], 12'h0}, 32); end
            7'h6F: begin
                e.fmt = 3'd6; pcrel = 1;
                imm   = sx({11'h0, o[31], o[19:12], o[20], o[30:21], 1'b0}, 21);
            end
            default: e.ill = 1'b1;
        endcase
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.imm = 64'(imm) & mask;
        e.tgt = pcrel ? ((p + 64'(imm)) & mask) : 64'h0;
        return e;
    endfunction

    function automatic logic [31:0] random_op();
        logic [31:0] r;
        logic [6:0]  opcs [8];
        opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom();
        if ($urandom_range(0, 9) == 0)
            return r;
        return {r[31:7], opcs[$urandom_range(0, 7)]};
    endfunction

    // One clock: called at the falling edge with inputs already driven.
    task automatic tick();
        bit   inx [3];
        bit   outx [3];
        exp_t e;
        #1;
        for (int d = 0; d < 3; d++) begin
            inx[d]  = rst_i && valid_i && o_rdy[d];
            outx[d] = o_vld[d] && ready_i;
            if (o_vld[d]) begin
                if (mc[d] == 0) begin
                    check_eq($sformatf("d%0d_spurious_vld", d), 64'(o_vld[d]), 64'h0);
                end else begin
                    e = mq[d][mh[d]];
                    check_eq($sformatf("d%0d_imm", d), o_imm[d], e.imm);
                    check_eq($sformatf("d%0d_fmt", d), 64'(o_fmt[d]), 64'(e.fmt));
                    check_eq($sformatf("d%0d_ill", d), 64'(o_ill[d]), 64'(e.ill));
                    check_eq($sformatf("d%0d_tgt", d), o_tgt[d], e.tgt);
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (flush_i || !rst_i) begin
                mc[d] = 0;
            end else begin
                if (outx[d] && mc[d] > 0) begin
                    mh[d] = (mh[d] + 1) % 4;
                    mc[d]--;
                end
                if (inx[d]) begin
                    mq[d][(mh[d] + mc[d]) % 4] = ref_model(op, pc, xl[d]);
                    mc[d]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("%s_d%0d_vld", tag, d), 64'(o_vld[d]), 64'h0);
            check_eq($sformatf("%s_d%0d_imm", tag, d), o_imm[d], 64'h0);
            check_eq($sformatf("%s_d%0d_tgt", tag, d), o_tgt[d], 64'h0);
            check_eq($sformatf("%s_d%0d_fmt", tag, d), 64'(o_fmt[d]), 64'h0);
            check_eq($sformatf("%s_d%0d_ill", tag, d), 64'(o_ill[d]), 64'h0);
        end
    endtask

    task automatic check_drained(input string tag);
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("%s_d%0d_left", tag, d), 64'(mc[d]), 64'h0);
    endtask

    // Directed vectors: op, pc, Imm, fmt, Target, illegal (XLEN=32 view).
    logic [31:0] t_op  [10] = '{32'hFFF00093, 32'h01F09093, 32'hFFF0F093, 32'hFE000EE3, 32'hFF9FF06F,
                                32'h0000007F, 32'h00001017, 32'h12345037, 32'hFE112E23, 32'hFFC08067};
    logic [31:0] t_pc  [10] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h4,
                                32'h200, 32'h10, 32'h10, 32'h10, 32'h40};
    logic [31:0] t_imm [10] = '{32'hFFFFFFFF, 32'h1F, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                32'h0, 32'h1000, 32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFFC};
    logic [2:0]  t_fmt [10] = '{3'd1, 3'd2, 3'd1, 3'd4, 3'd6, 3'd0, 3'd5, 3'd5, 3'd3, 3'd1};
    logic [31:0] t_tgt [10] = '{32'h0, 32'h0, 32'h0, 32'hFC, 32'hFFFFFFFC,
                                32'h0, 32'h1010, 32'h0, 32'h0, 32'h0};
    logic        t_ill [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic run_vector(input int v);
        valid_i = 1'b1; ready_i = 1'b1; op = t_op[v]; pc = {32'h0, t_pc[v]};
        tick();
        check_eq($sformatf("v%0d_l1_vld", v), 64'(o_vld[0]), 64'h1);
        check_eq($sformatf("v%0d_l1_imm", v), o_imm[0], {32'h0, t_imm[v]});
        check_eq($sformatf("v%0d_l1_fmt", v), 64'(o_fmt[0]), 64'(t_fmt[v]));
        check_eq($sformatf("v%0d_l1_tgt", v), o_tgt[0], {32'h0, t_tgt[v]});
        check_eq($sformatf("v%0d_l1_ill", v), 64'(o_ill[0]), 64'(t_ill[v]));
        check_eq($sformatf("v%0d_l2_early", v), 64'(o_vld[1]), 64'h0);
        valid_i = 1'b0;
        tick();
        check_eq($sformatf("v%0d_l2_vld", v), 64'(o_vld[1]), 64'h1);
        check_eq($sformatf("v%0d_l2_imm", v), o_imm[1], {32'h0, t_imm[v]});
        check_eq($sformatf("v%0d_l2_fmt", v), 64'(o_fmt[1]), 64'(t_fmt[v]));
        check_eq($sformatf("v%0d_l2_tgt", v), o_tgt[1], {32'h0, t_tgt[v]});
        check_eq($sformatf("v%0d_l2_ill", v), 64'(o_ill[1]), 64'(t_ill[v]));
        check_eq($sformatf("v%0d_l1_done", v), 64'(o_vld[0]), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s_imm, s_tgt;
        logic [2:0]  s_fmt;
        logic        s_ill;
        for (int d = 0; d < 3; d++) begin mh[d] = 0; mc[d] = 0; end
        rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op = '0; pc = '0;

        @(negedge clk); #1;
        check_idle_outputs("rst");
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("rst_rdy_d%0d", d), 64'(o_rdy[d]), 64'h1);

        for (int v = 0; v < 10; v++)
            run_vector(v);
        tick();

        // Stall with back-to-back inputs; stage-2 outputs must hold bit-stable.
        ready_i = 1'b0; valid_i = 1'b1; op = random_op(); pc = {$urandom(), $urandom()};
        tick();
        op = random_op(); pc = {$urandom(), $urandom()};
        tick();
        check_eq("stall_l2_rdy_full", 64'(o_rdy[1]), 64'h0);
        check_eq("stall_l2_vld", 64'(o_vld[1]), 64'h1);
        s_imm = o_imm[1]; s_tgt = o_tgt[1]; s_fmt = o_fmt[1]; s_ill = o_ill[1];
        for (int k = 0; k < 2; k++) begin
            op = random_op(); pc = {$urandom(), $urandom()};
            tick();
            check_eq("stall_hold_vld", 64'(o_vld[1]), 64'h1);
            check_eq("stall_hold_imm", o_imm[1], s_imm);
            check_eq("stall_hold_tgt", o_tgt[1], s_tgt);
            check_eq("stall_hold_fmt", 64'(o_fmt[1]), 64'(s_fmt));
            check_eq("stall_hold_ill", 64'(o_ill[1]), 64'(s_ill));
        end
        ready_i = 1'b1; valid_i = 1'b0;
        repeat (4) tick();
        check_drained("stall");

        // Flush with both stages full and a simultaneous input.
        ready_i = 1'b0; valid_i = 1'b1;
        repeat (2) begin op = random_op(); pc = {$urandom(), $urandom()}; tick(); end
        flush_i = 1'b1; op = 32'h00001017; pc = 64'h1234;
        #1;
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("flush_rdy_d%0d", d), 64'(o_rdy[d]), 64'h0);
        tick();
        flush_i = 1'b0;
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("flush_vld_d%0d", d), 64'(o_vld[d]), 64'h0);
        ready_i = 1'b1; valid_i = 1'b0;
        repeat (4) tick();
        check_drained("flush");

        // Asynchronous reset mid-stream.
        ready_i = 1'b0; valid_i = 1'b1;
        repeat (2) begin op = random_op(); pc = {$urandom(), $urandom()}; tick(); end
        valid_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        check_idle_outputs("arst");
        for (int d = 0; d < 3; d++) mc[d] = 0;
        @(negedge clk);
        rst_i = 1'b1;
        run_vector(3);
        tick();

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 7);
            flush_i = ($urandom_range(0, 29) == 0);
            op      = random_op();
            pc      = {$urandom(), $urandom()};
            tick();
        end
        flush_i = 1'b0; ready_i = 1'b1; valid_i = 1'b0;
        repeat (5) tick();
        check_drained("rand");

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage: decodes all RV32I/RV64I immediate formats, sign- or zero-extends them to XLEN and computes the PC-relative target for branch, JAL and AUIPC.
- Sits between the IF/ID register and the ID/EX register.
- Uses a valid/ready handshake with stall and flush support, so it can replace the purely combinational immediate path when decode is split across cycles.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets immediate and target width.
- LATENCY, 1, register stages from input acceptance to valid_o; legal values 1 or 2.

Ports:
- clk_i  input  1  clock; all registers on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  kill every in-flight entry; the input is not accepted this cycle.
- valid_i  input  1  Op_i/pc_i carry an instruction.
- ready_o  output  1  block can accept an input this cycle.
- Op_i  input  32  instruction word.
- pc_i  input  XLEN  PC of the instruction.
- valid_o  output  1  output entry valid.
- ready_i  input  1  downstream accepts the output.
- Imm_o  output  XLEN  extended immediate.
- fmt_o  output  3  immediate format code.
- Target_o  output  XLEN  pc + Imm for B/J/AUIPC, else 0.
- illegal_o  output  1  opcode carries no recognised immediate format.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All valid bits and all output registers clear: valid_o=0, Imm_o=0, Target_o=0, fmt_o=FMT_NONE, illegal_o=0.
  - ready_o=1 once reset is released.
- Transfers:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
- Decode by Op_i[6:0]:
  - 0010011 (OP-IMM): if funct3[1:0]==01 (slli/srli/srai), FMT_SHAMT with Imm = zero-extended shamt. The shamt is Op[24:20] when XLEN=32 and Op[25:20] when XLEN=64.
  - 0010011 (OP-IMM), all other funct3: FMT_I with Imm = sext(Op[31:20]).
  - 0000011 (load) and 1100111 (JALR): FMT_I with Imm = sext(Op[31:20]).
  - 0100011 (store): FMT_S with Imm = sext({Op[31:25],Op[11:7]}).
  - 1100011 (branch): FMT_B with Imm = sext({Op[31],Op[7],Op[30:25],Op[11:8],1'b0}).
  - 0110111 (LUI) and 0010111 (AUIPC): FMT_U with Imm = sext({Op[31:12],12'b0}).
  - 1101111 (JAL): FMT_J with Imm = sext({Op[31],Op[19:12],Op[20],Op[30:21],1'b0}).
  - Any other opcode: FMT_NONE, Imm=0, Target=0, illegal_o=1.
- Target:
  - (pc_i + Imm) mod 2^XLEN for FMT_B, FMT_J and AUIPC; wrap-around is silent.
  - 0 for every other instruction, including JALR (it needs rs1).
- LATENCY=1:
  - One stage; decode and add happen before the register.
  - ready_o = !valid_o || ready_i.
- LATENCY=2:
  - Stage 1 registers Imm, fmt, illegal, pc and an is_pcrel flag.
  - Stage 2 registers Target and passes the rest through.
  - Stage k advances when stage k+1 is empty or advancing.
  - ready_o = !v1 || stage 1 advancing.
  - Throughput is 1 per cycle when ready_i is held at 1.
- Stall:
  - While valid_o && !ready_i, all output ports hold bit-stable.
  - Upstream stages fill bubbles only, then hold.
- Flush:
  - flush_i=1 clears all valid bits at the next edge and forces ready_o=0 for that cycle.
  - A simultaneous valid_i is dropped.
  - Data registers may keep stale values, but valid_o=0.
  - flush_i has priority over a simultaneous output transfer; the downstream side discards it by the same flush.
- Reset mid-operation: all in-flight entries are discarded immediately and no partial output appears.
- Outputs are registered; there is no combinational path from Op_i to Imm_o.
- ready_o depends combinationally on ready_i and flush_i only.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt codes FMT_NONE=0, FMT_I=1, FMT_SHAMT=2, FMT_S=3, FMT_B=4, FMT_U=5, FMT_J=6;
  - opcode localparams OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
- Sub-module imm_decode (combinational, parametrised by XLEN): Op -> {Imm, fmt, illegal, is_pcrel}.
- The top level owns the pipeline registers, the handshake and the adder.

Test Plan:
- XLEN=32, LATENCY=1, Op=0xFFF00093 (addi x1,x0,-1), pc=0x0, ready_i=1 -> one cycle later valid_o=1, Imm_o=0xFFFFFFFF, fmt_o=FMT_I, Target_o=0, illegal_o=0.
- Op=0x01F09093 (slli x1,x1,31) -> Imm_o=0x0000001F, fmt_o=FMT_SHAMT. Op=0xFFF0F093 (andi) -> Imm_o=0xFFFFFFFF, fmt_o=FMT_I.
- Op=0xFE000EE3 (beq -4), pc=0x100 -> Imm_o=0xFFFFFFFC, fmt_o=FMT_B, Target_o=0xFC. Op=0xFF9FF06F (jal -8), pc=0x4 -> Target_o=0xFFFFFFFC (wrap).
- LATENCY=2, back-to-back inputs with ready_i=0 for 3 cycles:
  - outputs hold bit-stable while stalled;
  - ready_o falls once both stages are full;
  - no entry is lost or duplicated after ready_i=1;
  - each result arrives 2 cycles after acceptance.
- flush_i pulsed with both stages full and valid_i=1 -> valid_o=0 the next cycle and the dropped input never appears. Op=0x0000007F -> illegal_o=1, Imm_o=0.
- rst_i driven low asynchronously mid-stream -> valid_o=0 and all outputs zero before the next clock edge; after release the first new input emerges with correct values.
